uart_lease_scheduler: RTL and testbench



---
 rtl/uart_lease_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_lease_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lease_scheduler.sv
// uart_lease_scheduler
//   Grants one of N_NODES requesters an exclusive lease on the shared UART.
//   Arbitration uses the highest request priority. Ties go to the first node
//   after the previous owner in circular order. A lease watchdog revokes an
//   owner that stays idle too long. The owner's data bytes are forwarded to
//   the UART, and IRQ bytes from the UART are routed to the owner. The
//   peripheral is held in reset (rst_sig = 0) whenever it has no owner.
//
// Ports
//   CLK            in   system clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   in_op          in   op word per node, node k at [16k+15:16k]
//   in_peripheral  in   byte returned by the UART driver
//   out_peripheral out  byte to the UART driver
//   out_node       out  {owner_index+1, in_peripheral} to the owning node
//   grant          out  one-hot current owner, 0 when unowned
//   rst_sig        out  peripheral reset, 0 = held in reset
//   out_IRQ        out  per-node IRQ pulse
//   timeout        out  one-cycle pulse on forced lease revocation
//
// Optional feature macro: UART_AGING_EN
//   When defined, a waiting requester gains +1 effective priority for every
//   AGE_CYCLES cycles it waits, saturating at 15. The AGE_CYCLES parameter
//   exists only in that build.

module uart_lease_scheduler #(
  parameter int unsigned N_NODES      = 4,
  parameter logic [3:0]  TAG          = 4'hB,
  parameter int unsigned LEASE_CYCLES = 4096,
  parameter logic [7:0]  IRQ_CODE     = 8'h4E
`ifdef UART_AGING_EN
  ,
  parameter int unsigned AGE_CYCLES   = 256
`endif
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [16*N_NODES-1:0] in_op,
  input  logic [7:0]            in_peripheral,
  output logic [7:0]            out_peripheral,
  output logic [15:0]           out_node,
  output logic [N_NODES-1:0]    grant,
  output logic                  rst_sig,
  output logic [N_NODES-1:0]    out_IRQ,
  output logic                  timeout
);

  localparam int unsigned IDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int unsigned CNT_W = (LEASE_CYCLES > 1) ? $clog2(LEASE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_LOCKED = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [15:0]        w_op   [N_NODES];
  logic [N_NODES-1:0] w_ctrl;
  logic [N_NODES-1:0] w_req;
  logic [N_NODES-1:0] w_rel;
  logic [N_NODES-1:0] w_data;
  logic [3:0]         w_eff  [N_NODES];

  logic               w_win_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic [3:0]         w_win_prio;
  logic [IDX_W-1:0]   w_scan;

  // Index 'step' positions after 'base', wrapping at N_NODES.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int               step);
    int v;
    v = int'(base) + step;
    if (v >= int'(N_NODES)) v = v - int'(N_NODES);
    return IDX_W'(v);
  endfunction

  // Per-node control-word decode.
  always_comb begin
    for (int k = 0; k < N_NODES; k++) begin
      w_op[k]   = in_op[16*k +: 16];
      w_ctrl[k] = (w_op[k][15:12] == 4'hF) && (w_op[k][11:8] == TAG);
      w_req[k]  = w_ctrl[k] && (w_op[k][7:4] == 4'h0) && (w_op[k][3:0] != 4'h0);
      w_rel[k]  = w_ctrl[k] && (w_op[k][7:0] == 8'hFF);
      w_data[k] = (w_op[k] != 16'h0000) && !w_ctrl[k];
    end
  end

`ifdef UART_AGING_EN
  localparam int unsigned AGE_W = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;

  logic [AGE_W-1:0] r_age_cnt [N_NODES];
  logic [3:0]       r_age_lvl [N_NODES];
  logic [4:0]       w_sum     [N_NODES];

  // Effective priority = request priority + age level, saturating at 15.
  always_comb begin
    for (int k = 0; k < N_NODES; k++) begin
      w_sum[k] = {1'b0, w_op[k][3:0]} + {1'b0, r_age_lvl[k]};
      w_eff[k] = w_sum[k][4] ? 4'hF : w_sum[k][3:0];
    end
  end
`else
  // Effective priority is the raw request priority.
  always_comb begin
    for (int k = 0; k < N_NODES; k++) begin
      w_eff[k] = w_op[k][3:0];
    end
  end
`endif

  // Scan starts just after the last owner. A later node wins only on a
  // strictly higher priority, so ties keep the circular order.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_win_prio  = '0;
    w_scan      = '0;
    for (int i = 1; i <= int'(N_NODES); i++) begin
      w_scan = rr_idx(r_last, i);
      if (w_req[w_scan] && (!w_win_valid || (w_eff[w_scan] > w_win_prio))) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_scan;
        w_win_prio  = w_eff[w_scan];
      end
    end
  end

  // Lease state machine with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= S_IDLE;
      r_owner        <= '0;
      r_last         <= IDX_W'(N_NODES - 1);
      r_cnt          <= '0;
      out_peripheral <= '0;
      out_node       <= '0;
      grant          <= '0;
      rst_sig        <= 1'b0;
      out_IRQ        <= '0;
      timeout        <= 1'b0;
    end else begin
      out_IRQ <= '0;
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          out_peripheral <= '0;
          out_node       <= '0;
          grant          <= '0;
          rst_sig        <= 1'b0;
          if (w_win_valid) begin
            r_owner <= w_win_idx;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          grant   <= N_NODES'(1) << r_owner;
          rst_sig <= 1'b1;
          r_cnt   <= CNT_W'(LEASE_CYCLES - 1);
          r_state <= S_LOCKED;
        end
        S_LOCKED: begin
          if (in_peripheral == IRQ_CODE) begin
            out_IRQ <= N_NODES'(1) << r_owner;
          end
          // Release beats expiry. Data and keep-alive requests reload the
          // watchdog. Anything else from the owner counts as idle.
          if (w_rel[r_owner]) begin
            r_state <= S_DRAIN;
          end else if (w_data[r_owner]) begin
            out_peripheral <= w_op[r_owner][7:0];
            out_node       <= {8'(r_owner) + 8'd1, in_peripheral};
            r_cnt          <= CNT_W'(LEASE_CYCLES - 1);
          end else if (w_req[r_owner]) begin
            r_cnt <= CNT_W'(LEASE_CYCLES - 1);
          end else if (r_cnt == '0) begin
            timeout <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          out_peripheral <= '0;
          out_node       <= '0;
          grant          <= '0;
          rst_sig        <= 1'b0;
          r_last         <= r_owner;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_AGING_EN
  // Age counters. A node ages only while it is requesting and does not own
  // the lease. The age clears on grant or when the request is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N_NODES; k++) begin
        r_age_cnt[k] <= '0;
        r_age_lvl[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_NODES; k++) begin
        if (!w_req[k] ||
            ((r_state == S_IDLE) && w_win_valid && (w_win_idx == IDX_W'(k))) ||
            ((r_state != S_IDLE) && (r_owner == IDX_W'(k)))) begin
          r_age_cnt[k] <= '0;
          r_age_lvl[k] <= '0;
        end else if (r_age_cnt[k] == AGE_W'(AGE_CYCLES - 1)) begin
          r_age_cnt[k] <= '0;
          if (r_age_lvl[k] != 4'hF) r_age_lvl[k] <= r_age_lvl[k] + 4'd1;
        end else begin
          r_age_cnt[k] <= r_age_cnt[k] + AGE_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_lease_scheduler.sv
// Bench for uart_lease_scheduler. It runs a set of directed scenarios with
// literal expectations, followed by randomized op traffic. A lease-level
// reference model predicts every output, and the outputs are compared to it
// on each falling clock edge.
`timescale 1ns/1ps
module tb_uart_lease_scheduler;

  localparam int unsigned N     = 4;
  localparam int unsigned LEASE = 16;
  localparam logic [3:0]  TAGV  = 4'hB;
  localparam logic [7:0]  IRQV  = 8'h4E;

  localparam int P_FREE   = 0;  // no lease; requests are evaluated
  localparam int P_CHOSEN = 1;  // owner picked; lease becomes visible next
  localparam int P_HELD   = 2;  // owner active
  localparam int P_ENDING = 3;  // lease ending; outputs clear next

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [16*N-1:0] in_op;
  logic [7:0]      in_peripheral;
  logic [7:0]      out_peripheral;
  logic [15:0]     out_node;
  logic [N-1:0]    grant;
  logic            rst_sig;
  logic [N-1:0]    out_IRQ;
  logic            timeout;

  logic [15:0]     op [N];

  int n_checks = 0;
  int n_fail   = 0;
  bit checking_on = 1'b0;

  uart_lease_scheduler #(
    .N_NODES(N), .TAG(TAGV), .LEASE_CYCLES(LEASE), .IRQ_CODE(IRQV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .in_op(in_op), .in_peripheral(in_peripheral),
    .out_peripheral(out_peripheral), .out_node(out_node), .grant(grant),
    .rst_sig(rst_sig), .out_IRQ(out_IRQ), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < N; k++) in_op[16*k +: 16] = op[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ctrl(input logic [15:0] w);
    return (w[15:12] == 4'hF) && (w[11:8] == TAGV);
  endfunction
  function automatic bit is_req(input logic [15:0] w);
    return is_ctrl(w) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
  endfunction
  function automatic bit is_rel(input logic [15:0] w);
    return is_ctrl(w) && (w[7:0] == 8'hFF);
  endfunction
  function automatic bit is_data(input logic [15:0] w);
    return (w != 16'h0000) && !is_ctrl(w);
  endfunction

  // ---------------- reference model (lease-level) ----------------
  int          m_phase, m_owner, m_last, m_idle;
  logic [7:0]  e_pout;
  logic [15:0] e_node;
  logic [N-1:0] e_grant, e_irq;
  logic        e_rst, e_to;

  always @(posedge CLK or negedge RST_N) begin : model
    int best;
    if (!RST_N) begin
      m_phase = P_FREE; m_owner = 0; m_last = N - 1; m_idle = 0;
      e_pout = '0; e_node = '0; e_grant = '0; e_rst = 1'b0; e_irq = '0; e_to = 1'b0;
    end else begin
      e_irq = '0;
      e_to  = 1'b0;
      if (m_phase == P_FREE) begin
        e_pout = '0; e_node = '0; e_grant = '0; e_rst = 1'b0;
        best = -1;
        for (int i = 1; i <= N; i++) begin
          int n;
          n = (m_last + i) % N;
          if (is_req(op[n]) && (best < 0 || op[n][3:0] > op[best][3:0])) best = n;
        end
        if (best >= 0) begin m_owner = best; m_phase = P_CHOSEN; end
      end else if (m_phase == P_CHOSEN) begin
        e_grant = '0;
        e_grant[m_owner] = 1'b1;
        e_rst   = 1'b1;
        m_idle  = 0;
        m_phase = P_HELD;
      end else if (m_phase == P_HELD) begin
        if (in_peripheral == IRQV) e_irq[m_owner] = 1'b1;
        if (is_rel(op[m_owner])) begin
          m_phase = P_ENDING;
        end else if (is_data(op[m_owner])) begin
          e_pout = op[m_owner][7:0];
          e_node = {8'(m_owner + 1), in_peripheral};
          m_idle = 0;
        end else if (is_req(op[m_owner])) begin
          m_idle = 0;
        end else begin
          // One more consecutive idle cycle; the LEASE-th one revokes.
          m_idle++;
          if (m_idle == LEASE) begin e_to = 1'b1; m_phase = P_ENDING; end
        end
      end else begin
        e_pout = '0; e_node = '0; e_grant = '0; e_rst = 1'b0;
        m_last  = m_owner;
        m_phase = P_FREE;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (checking_on) begin
      check("cyc_grant",   32'(grant),          32'(e_grant));
      check("cyc_rst_sig", 32'(rst_sig),        32'(e_rst));
      check("cyc_pout",    32'(out_peripheral), 32'(e_pout));
      check("cyc_node",    32'(out_node),       32'(e_node));
      check("cyc_irq",     32'(out_IRQ),        32'(e_irq));
      check("cyc_timeout", 32'(timeout),        32'(e_to));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2)      w = 16'h0000;
    else if (r <= 4) w = {4'hF, TAGV, 4'h0, 4'($urandom_range(1, 15))};
    else if (r == 5) w = {4'hF, TAGV, 8'hFF};
    else if (r == 8) begin
      w = {4'hF, TAGV, 4'($urandom_range(1, 15)), 4'($urandom)};
      if (w[7:0] == 8'hFF) w[7:0] = 8'hFE;
    end else if (r == 9) w = {4'hF, 4'hA, 8'($urandom)};
    else begin
      w = 16'($urandom);
      if (is_ctrl(w)) w[15] = 1'b0;
      if (w == 16'h0000) w = 16'h0001;
    end
    return w;
  endfunction

  initial begin
    RST_N = 1'b0;
    in_peripheral = 8'h00;
    for (int k = 0; k < N; k++) op[k] = 16'h0000;
    repeat (3) tick();
    checking_on = 1'b1;
    #1;
    check("rst_grant",   32'(grant),          32'h0);
    check("rst_rst_sig", 32'(rst_sig),        32'h0);
    check("rst_pout",    32'(out_peripheral), 32'h0);
    check("rst_node",    32'(out_node),       32'h0);
    check("rst_irq",     32'(out_IRQ),        32'h0);
    check("rst_timeout", 32'(timeout),        32'h0);

    // Single requester after reset: one IDLE cycle, then the grant.
    tick(); RST_N = 1'b1; op[1] = 16'hFB05;
    tick(); check("t1_idle_grant", 32'(grant), 32'h0);
    tick(); check("t1_grant", 32'(grant), 32'h2);
            check("t1_rst_sig", 32'(rst_sig), 32'h1);
    op[1] = 16'hFBFF; tick();
    op[1] = 16'h0000; tick();
    check("t1_drain_grant", 32'(grant), 32'h0);
    check("t1_drain_rst", 32'(rst_sig), 32'h0);

    // Equal priority with last_owner=1: node3 comes first, then node1.
    op[1] = 16'hFB07; op[3] = 16'hFB07;
    tick(); tick(); check("t3_first", 32'(grant), 32'h8);
    op[3] = 16'hFBFF; tick();
    op[3] = 16'h0000; tick(); tick(); tick();
    check("t3_second", 32'(grant), 32'h2);
    op[1] = 16'hFBFF; tick();
    op[1] = 16'h0000; tick();

    // Priority arbitration, data forwarding, IRQ routing.
    op[0] = 16'hFB03; op[2] = 16'hFB09;
    tick(); tick(); check("t2_grant", 32'(grant), 32'h4);
    op[2] = 16'h0041; in_peripheral = 8'h12;
    tick(); check("t2_pout", 32'(out_peripheral), 32'h41);
            check("t2_node", 32'(out_node), 32'h0312);
    op[2] = 16'h0000; in_peripheral = IRQV;
    tick(); check("t5_irq", 32'(out_IRQ), 32'h4);
    in_peripheral = 8'h00;
    tick(); check("t5_irq_end", 32'(out_IRQ), 32'h0);
            check("t2_hold", 32'(out_peripheral), 32'h41);
    op[2] = 16'hFBFF; tick();
    op[2] = 16'h0000; tick();
    check("t2_drain_pout", 32'(out_peripheral), 32'h0);
    tick(); tick(); check("t2_queued", 32'(grant), 32'h1);

    // Idle owner revoked after LEASE idle cycles; queued node3 follows.
    op[0] = 16'h0000; op[3] = 16'hFB02;
    repeat (15) tick();
    check("t4_no_timeout", 32'(timeout), 32'h0);
    tick(); check("t4_timeout", 32'(timeout), 32'h1);
    tick(); check("t4_to_end", 32'(timeout), 32'h0);
            check("t4_drain_rst", 32'(rst_sig), 32'h0);
    tick(); tick(); check("t4_next", 32'(grant), 32'h8);

    // Request word held by the owner acts as keep-alive.
    repeat (20) tick();
    check("keepalive_grant", 32'(grant), 32'h8);
    check("keepalive_rst", 32'(rst_sig), 32'h1);

    // Asynchronous reset mid-lease.
    op[3] = 16'h00A5;
    tick(); check("t5_pout", 32'(out_peripheral), 32'hA5);
            check("t5_node", 32'(out_node), 32'h0400);
    RST_N = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 32'h0);
    check("t5_async_rst",   32'(rst_sig), 32'h0);
    check("t5_async_pout",  32'(out_peripheral), 32'h0);
    check("t5_async_node",  32'(out_node), 32'h0);
    op[3] = 16'h0000;
    tick(); RST_N = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) op[k] = rand_word();
      end
      in_peripheral = ($urandom_range(0, 9) == 0) ? IRQV : 8'($urandom);
      RST_N = ($urandom_range(0, 399) != 0);
      tick();
    end

    RST_N = 1'b1;
    for (int k = 0; k < N; k++) op[k] = 16'h0000;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
